// File: rtl/dreg_array_pipe_pkg.sv
// Shared constants and helpers for the dreg_array_pipe multi-lane delay line.
// Optional parity support is enabled by defining DREG_ARRAY_PIPE_PARITY_EN.
package dreg_array_pipe_pkg;

    localparam int DEF_N     = 8;
    localparam int DEF_M     = 4;
    localparam int DEF_DEPTH = 3;

    // Occupancy must represent 0..depth inclusive, so one extra code is needed.
    function automatic int clog2_occ(input int depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

    typedef struct packed {
        logic               par;
        logic [DEF_N-1:0]   data;
    } par_word_t;

endpackage

// File: rtl/dreg_array_pipe_lane.sv
// One lane of the pipeline: DEPTH data/valid stages, flush, occupancy counter.
// With DREG_ARRAY_PIPE_PARITY_EN each stage also carries an even-parity bit.
module dreg_array_pipe_lane
    import dreg_array_pipe_pkg::*;
#(
    parameter int N     = DEF_N,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          ce,
    input  logic                          flush,
    input  logic [N-1:0]                  d,
    input  logic                          d_valid,
    output logic [N-1:0]                  q,
    output logic                          q_valid,
`ifdef DREG_ARRAY_PIPE_PARITY_EN
    output logic                          par_err,
`endif
    output logic [clog2_occ(DEPTH)-1:0]   occ
);

    localparam int OW = clog2_occ(DEPTH);

`ifdef DREG_ARRAY_PIPE_PARITY_EN
    typedef struct packed {
        logic         par;
        logic [N-1:0] data;
    } stage_t;
`else
    typedef struct packed {
        logic [N-1:0] data;
    } stage_t;
`endif

    stage_t          stg [0:DEPTH-1];
    logic [DEPTH-1:0] valid_r;
    logic [OW-1:0]   occ_r;
    logic            v_last;

    assign v_last = valid_r[DEPTH-1];

    // Flush freezes the data path as well, so a flushed lane keeps its contents.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                stg[k] <= '0;
            end
        end else if (ce && !flush) begin
            stg[0].data <= d;
`ifdef DREG_ARRAY_PIPE_PARITY_EN
            stg[0].par  <= ^d;
`endif
            for (int k = 1; k < DEPTH; k++) begin
                stg[k] <= stg[k-1];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            valid_r <= '0;
            occ_r   <= '0;
        end else if (ce) begin
            valid_r[0] <= d_valid;
            for (int k = 1; k < DEPTH; k++) begin
                valid_r[k] <= valid_r[k-1];
            end
            if (d_valid && !v_last) begin
                occ_r <= occ_r + OW'(1);
            end else if (!d_valid && v_last) begin
                occ_r <= occ_r - OW'(1);
            end
        end
    end

`ifdef DREG_ARRAY_PIPE_PARITY_EN
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            par_err <= 1'b0;
        end else begin
            par_err <= v_last & ((^stg[DEPTH-1].data) ^ stg[DEPTH-1].par);
        end
    end
`endif

    assign q       = stg[DEPTH-1].data;
    assign q_valid = v_last;
    assign occ     = occ_r;

endmodule

// File: rtl/dreg_array_pipe.sv
// M-lane, DEPTH-stage stallable delay line with per-lane valid, flush and occupancy.
// Defining DREG_ARRAY_PIPE_PARITY_EN adds per-stage parity and the par_err output.
module dreg_array_pipe
    import dreg_array_pipe_pkg::*;
#(
    parameter int N     = DEF_N,
    parameter int M     = DEF_M,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          ce,
    input  logic                          flush   [0:M-1],
    input  logic [N-1:0]                  d       [0:M-1],
    input  logic                          d_valid [0:M-1],
    output logic [N-1:0]                  q       [0:M-1],
    output logic                          q_valid [0:M-1],
`ifdef DREG_ARRAY_PIPE_PARITY_EN
    output logic                          par_err [0:M-1],
`endif
    output logic [clog2_occ(DEPTH)-1:0]   occ     [0:M-1]
);

    for (genvar i = 0; i < M; i++) begin : g_lane
        dreg_array_pipe_lane #(
            .N     (N),
            .DEPTH (DEPTH)
        ) u_lane (
            .clock   (clock),
            .reset   (reset),
            .ce      (ce),
            .flush   (flush[i]),
            .d       (d[i]),
            .d_valid (d_valid[i]),
            .q       (q[i]),
            .q_valid (q_valid[i]),
`ifdef DREG_ARRAY_PIPE_PARITY_EN
            .par_err (par_err[i]),
`endif
            .occ     (occ[i])
        );
    end

endmodule
